// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Shared constants and the parameter-legality helper for the d_flip_flop
// register slice.
//   DFF_MAX_WIDTH  : widest supported data path
//   DFF_MAX_STAGES : deepest supported register chain
//   check_params() : returns 1 when WIDTH and STAGES are both in range
// -----------------------------------------------------------------------------
package dff_pkg;

    localparam int DFF_MAX_WIDTH  = 32'sd64;
    localparam int DFF_MAX_STAGES = 32'sd16;

    // True when both the width and the stage count lie in the supported range.
    function automatic bit check_params(input int width, input int stages);
        bit ok;
        ok = (width >= 32'sd1) && (width <= DFF_MAX_WIDTH) &&
             (stages >= 32'sd1) && (stages <= DFF_MAX_STAGES);
        return ok;
    endfunction

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// -----------------------------------------------------------------------------
// dff_stage
// One WIDTH-bit register with a synchronous, active-low reset.
//   clock : rising-edge clock
//   reset : synchronous reset, 0 = load RESET_VALUE at the next rising edge
//   d     : data captured at every rising edge while reset is 1
//   q     : register contents (no combinational path from d)
// -----------------------------------------------------------------------------
module dff_stage #(
    parameter int               WIDTH       = 32'sd1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state selection: reset has priority over new data.
    always_comb begin
        data_d = RESET_VALUE;
        if (!reset) begin
            data_d = RESET_VALUE;
        end else begin
            data_d = d;
        end
    end

    // State register; reset is only seen at the rising edge.
    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule : dff_stage

// File: rtl/d_flip_flop.sv
// -----------------------------------------------------------------------------
// d_flip_flop
// Positive-edge register chain of STAGES cascaded WIDTH-bit flops with a
// synchronous, active-low reset that clears every stage in a single edge.
//   clock : rising-edge clock
//   reset : synchronous reset, 0 = every stage loads RESET_VALUE
//   d     : data input, appears on q STAGES rising edges later
//   q     : output taken straight from the last stage's register
// A RESET_VALUE wider than WIDTH is truncated to its low WIDTH bits by the
// typed parameter declaration.
// -----------------------------------------------------------------------------
module d_flip_flop
    import dff_pkg::*;
#(
    parameter int               WIDTH       = 32'sd1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               STAGES      = 32'sd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Refuse to elaborate an empty or oversized chain.
    if (!check_params(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "d_flip_flop: WIDTH (%0d) or STAGES (%0d) out of range", WIDTH, STAGES);
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] stage_in_s;

        // Stage 0 samples the external input; later stages sample their predecessor.
        if (i == 0) begin : g_first
            assign stage_in_s = d;
        end else begin : g_next
            assign stage_in_s = stage_q[i-1];
        end

        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .d     (stage_in_s),
            .q     (stage_q[i])
        );
    end

    assign q = stage_q[STAGES-1];

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// -----------------------------------------------------------------------------
// tb_d_flip_flop
// Drives a default 1-bit single flop (dut_a) and an 8-bit, 3-stage chain with
// reset value 8'hA5 (dut_b) from one clock. Every rising edge the inputs that
// were stable at that edge are logged; the expected q is derived from that log:
// if any of the last STAGES edges saw reset low, q is the reset value,
// otherwise q is the d logged STAGES edges ago.
// -----------------------------------------------------------------------------
module tb_d_flip_flop;

    typedef logic [63:0] vq_t [$];
    typedef bit          bq_t [$];

    logic       clock = 1'b0;
    logic       rst_a;
    logic       d_a;
    logic       q_a;
    logic       rst_b;
    logic [7:0] d_b;
    logic [7:0] q_b;

    int tests_run    = 0;
    int tests_failed = 0;

    bq_t ha_rst;
    vq_t ha_d;
    bq_t hb_rst;
    vq_t hb_d;

    always #10 clock = ~clock;

    d_flip_flop u_dut_a (
        .clock (clock),
        .reset (rst_a),
        .d     (d_a),
        .q     (q_a)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .STAGES      (3)
    ) u_dut_b (
        .clock (clock),
        .reset (rst_b),
        .d     (d_b),
        .q     (q_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected q after the most recent logged edge.
    function automatic logic [63:0] model_q(input bq_t rh, input vq_t dh,
                                            input int stages, input logic [63:0] rv);
        int n;
        n = rh.size();
        for (int j = 0; j < stages; j++) begin
            if (n - 1 - j < 0) return 64'hx;
            if (rh[n-1-j] == 1'b0) return rv;
        end
        return dh[n-stages];
    endfunction

    // Log the inputs about to be sampled, take one edge, then check both DUTs.
    task automatic tick(input string tag);
        ha_rst.push_back(rst_a);
        ha_d.push_back({63'b0, d_a});
        hb_rst.push_back(rst_b);
        hb_d.push_back({56'b0, d_b});
        @(posedge clock);
        #1;
        check_eq({tag, "_a"}, {63'b0, q_a}, model_q(ha_rst, ha_d, 1, 64'h0));
        check_eq({tag, "_b"}, {56'b0, q_b}, model_q(hb_rst, hb_d, 3, 64'hA5));
    endtask

    initial begin
        rst_a = 1'b0;
        d_a   = 1'b1;
        rst_b = 1'b0;
        d_b   = 8'h3C;

        // Reset load on both configurations.
        tick("reset_load");
        check_eq("reset_a_const", {63'b0, q_a}, 64'h0);
        check_eq("reset_b_const", {56'b0, q_b}, 64'hA5);

        // Capture on the single flop; chain released with d=3C.
        rst_a = 1'b1;
        d_a   = 1'b1;
        rst_b = 1'b1;
        d_b   = 8'h3C;
        tick("capture1");
        check_eq("capture1_a_const", {63'b0, q_a}, 64'h1);
        check_eq("pipe_edge1_const", {56'b0, q_b}, 64'hA5);
        d_a = 1'b0;
        tick("capture0");
        check_eq("capture0_a_const", {63'b0, q_a}, 64'h0);
        check_eq("pipe_edge2_const", {56'b0, q_b}, 64'hA5);
        d_a = 1'b1;
        tick("pipe3");
        check_eq("pipe_edge3_const", {56'b0, q_b}, 64'h3C);
        check_eq("q_a_set_const", {63'b0, q_a}, 64'h1);

        // Reset pulse entirely between edges must not touch q.
        #4 rst_a = 1'b0;
        #1 check_eq("async_low_mid", {63'b0, q_a}, 64'h1);
        #3 rst_a = 1'b1;
        #1 check_eq("async_after_pulse", {63'b0, q_a}, 64'h1);
        tick("async_next_edge");
        check_eq("async_held_const", {63'b0, q_a}, 64'h1);
        rst_a = 1'b0;
        tick("sync_reset");
        check_eq("sync_reset_const", {63'b0, q_a}, 64'h0);

        // d glitch 0->1->0 between edges; only the settled 0 is captured.
        rst_a = 1'b1;
        d_a   = 1'b0;
        #3 d_a = 1'b1;
        #3 d_a = 1'b0;
        tick("glitch");
        check_eq("glitch_const", {63'b0, q_a}, 64'h0);

        // Fill the chain with fresh data, then reset mid-stream.
        d_a = 1'b1;
        d_b = 8'h11;
        tick("stream1");
        d_b = 8'h22;
        tick("stream2");
        rst_b = 1'b0;
        d_b   = 8'h33;
        tick("mid_reset");
        check_eq("mid_reset_const", {56'b0, q_b}, 64'hA5);
        rst_b = 1'b1;

        // Reset priority: q was 1, reset low with d=1 at the same edge.
        check_eq("prio_pre_const", {63'b0, q_a}, 64'h1);
        rst_a = 1'b0;
        d_a   = 1'b1;
        tick("priority");
        check_eq("priority_const", {63'b0, q_a}, 64'h0);
        rst_a = 1'b1;

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 300; k++) begin
            rst_a = ($urandom_range(0, 7) != 0);
            rst_b = ($urandom_range(0, 9) != 0);
            d_a   = 1'($urandom_range(0, 1));
            d_b   = 8'($urandom);
            // Occasionally glitch inputs mid-cycle before they settle.
            if ($urandom_range(0, 3) == 0) begin
                #3;
                d_b   = ~d_b;
                rst_b = ~rst_b;
                #3;
                d_b   = ~d_b;
                rst_b = ~rst_b;
            end
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_d_flip_flop

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Positive-edge D flip-flop with synchronous, active-low reset. Used as the basic storage/retiming element in the design.
- Width, reset value and number of register stages are set by parameters.
- Defaults give a single 1-bit flop: q follows d one clock later and clears to 0 under reset.

Parameters:
- WIDTH, 1, bit width of d and q; legal range 1..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every stage on reset.
- STAGES, 1, number of cascaded register stages (d-to-q latency in clocks); legal range 1..16.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset. 0 means reset, sampled only at the rising edge of clock.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered output, driven directly from the last stage's register with no combinational path from d.

Behaviour:
- One clock; reset is synchronous and active-low.
- At each rising edge of clock:
  - if reset==0, every stage loads RESET_VALUE;
  - else stage[0] <= d and stage[i] <= stage[i-1] for i=1..STAGES-1.
- q = stage[STAGES-1].
- Reset value of q is RESET_VALUE, visible immediately after the first rising edge at which reset==0.
- Reset is never asynchronous. A falling reset between edges has no effect on q until the next rising edge.
- Latency is STAGES clocks. With STAGES=1, d sampled at edge N appears on q after edge N and holds until edge N+1.
- Reset mid-operation clears all in-flight data in every stage in a single edge. No partial flush.
- Reset deassertion: the first edge with reset==1 loads d into stage[0]. Downstream stages still hold RESET_VALUE until the data propagates.
- d and reset changes between edges (glitches) are ignored. Only values stable at the rising edge matter.
- Simultaneous reset==0 and a new d at the same edge: reset wins and q = RESET_VALUE.
- Before the first rising edge, q is unknown. No initial-value or power-on behaviour is guaranteed.
- No enable: the register loads every cycle.
- Elaboration checks:
  - STAGES<1 or WIDTH<1 is a fatal error.
  - RESET_VALUE wider than WIDTH is truncated to its low WIDTH bits.

Decomposition:
- Shared package dff_pkg:
  - constant DFF_MAX_WIDTH=64;
  - constant DFF_MAX_STAGES=16;
  - function check_params used by the elaboration assertions.
- One natural sub-module, dff_stage: a single WIDTH-bit register with synchronous active-low reset to RESET_VALUE.
- d_flip_flop instantiates STAGES copies of dff_stage in a generate chain.

Test Plan:
- Reset load (defaults, 20-unit clock period): reset=0, d=1 held across the rising edge -> q=0 after that edge.
- Capture: reset=1, d=1 at edge N -> q=1 after edge N. Then d=0 before edge N+1 -> q=0 after edge N+1.
- Synchronous, not asynchronous: q=1, drive reset=0 at 5 units after an edge and back to 1 before the next edge -> q stays 1 throughout. Then reset=0 held across the next edge -> q=0 after that edge only.
- Mid-cycle d glitch: reset=1, d toggles 0->1->0 entirely between two edges -> q unchanged at the next edge (captures 0).
- Pipeline (WIDTH=8, STAGES=3, RESET_VALUE=8'hA5):
  - reset asserted -> q=8'hA5;
  - release reset and drive d=8'h3C -> q stays 8'hA5 for 2 edges and equals 8'h3C after the 3rd edge.
  - Assert reset mid-stream -> q=8'hA5 after one edge.
- Reset priority: reset=0 and d=1 changing at the same edge -> q=RESET_VALUE, not 1.
